// File: rtl/icache_refill_arbiter_nch.sv
// icache_refill_arbiter_nch
// Merges instruction-cache refill requests from NB_CHANNELS sources onto a
// single L1.5 refill port. Channel 0 (demand miss) may optionally take strict
// priority; all other choices are round-robin. A request that is presented but
// not yet granted is locked so the downstream address stays stable. Granted
// channel IDs are queued so in-order responses route back to their issuer.

module icache_refill_arbiter_nch #(
  parameter int NB_CHANNELS       = 2,
  parameter int FETCH_ADDR_WIDTH  = 32,
  parameter int REFILL_DATA_WIDTH = 128,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int PRIO_CH0          = 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NB_CHANNELS-1:0]                           ch_req_i,
  input  logic [NB_CHANNELS-1:0][FETCH_ADDR_WIDTH-1:0]     ch_addr_i,
  output logic [NB_CHANNELS-1:0]                           ch_gnt_o,
  output logic [NB_CHANNELS-1:0]                           ch_r_valid_o,
  output logic [REFILL_DATA_WIDTH-1:0]                     ch_r_data_o,
  output logic                                             arbiter_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0]                      arbiter_addr_o,
  input  logic                                             arbiter_gnt_i,
  input  logic                                             arbiter_r_valid_i,
  input  logic [REFILL_DATA_WIDTH-1:0]                     arbiter_r_data_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]             outstanding_o,
  output logic                                             rsp_err_o
);

  localparam int IDX_W = $clog2(NB_CHANNELS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NB_CHANNELS - 1);

  typedef enum logic {
    ST_FREE,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic               lock_rr_q, lock_rr_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]   id_fifo_q [MAX_OUTSTANDING];
  logic               rsp_err_q;

  logic [IDX_W-1:0]   rr_sel;
  logic [IDX_W-1:0]   rr_cand;
  logic               rr_found;
  logic [IDX_W-1:0]   sel;
  logic               sel_rr;
  logic               grant;
  logic               pop;
  logic [IDX_W-1:0]   head;

  // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
  always_comb begin
    rr_sel   = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NB_CHANNELS; i++) begin
      rr_cand = IDX_W'((int'(rr_ptr_q) + i) % NB_CHANNELS);
      if (!rr_found && ch_req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  // Lock FSM next state, channel selection and downstream request/grant.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    lock_rr_d  = lock_rr_q;
    sel        = rr_sel;
    sel_rr     = 1'b1;
    ch_gnt_o   = '0;

    if (state_q == ST_LOCKED) begin
      sel    = lock_idx_q;
      sel_rr = lock_rr_q;
    end else if ((PRIO_CH0 != 0) && ch_req_i[0]) begin
      sel    = '0;
      sel_rr = 1'b0;
    end

    arbiter_req_o  = rst_n && (|ch_req_i) && (count_q < MAX_CNT);
    arbiter_addr_o = ch_addr_i[sel];
    grant          = arbiter_req_o && arbiter_gnt_i;

    if (grant) begin
      ch_gnt_o[sel] = 1'b1;
    end

    if (arbiter_req_o && !arbiter_gnt_i) begin
      state_d    = ST_LOCKED;
      lock_idx_d = sel;
      lock_rr_d  = sel_rr;
    end else if (grant) begin
      state_d = ST_FREE;
    end
  end

  // Response routing: the FIFO head names the channel that owns this response.
  always_comb begin
    head         = id_fifo_q[rd_ptr_q];
    pop          = arbiter_r_valid_i && (count_q != '0);
    ch_r_valid_o = '0;
    if (pop) begin
      ch_r_valid_o[head] = 1'b1;
    end
    ch_r_data_o = arbiter_r_data_i;
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FREE;
      lock_idx_q <= '0;
      lock_rr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      lock_rr_q  <= lock_rr_d;
    end
  end

  // Round-robin pointer moves past the winner only for round-robin grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (grant && sel_rr) begin
      rr_ptr_q <= (sel == LAST_CH) ? '0 : sel + IDX_W'(1);
    end
  end

  // ID FIFO storage and pointers, plus the in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_fifo_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({grant, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error for a response that arrives with nothing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (arbiter_r_valid_i && (count_q == '0)) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign rsp_err_o     = rsp_err_q;

endmodule
